// File: rtl/medidor_carga_bateria_if.sv
//------------------------------------------------------------------------------
// Module  : medidor_carga_bateria_if
// Brief   : Pulse inputs and level/status outputs of the dual-battery gauge.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface medidor_carga_bateria_if;
  logic       consumo;
  logic       recarga1;
  logic       recarga2;
  logic [3:0] carga_bateria1;
  logic [3:0] carga_bateria2;
  logic [1:0] fuente_activa;
  logic       actualizado;
  logic       consumo_perdido;

  modport master (
    output consumo, recarga1, recarga2,
    input  carga_bateria1, carga_bateria2, fuente_activa, actualizado, consumo_perdido
  );

  modport slave (
    input  consumo, recarga1, recarga2,
    output carga_bateria1, carga_bateria2, fuente_activa, actualizado, consumo_perdido
  );
endinterface

`default_nettype wire

// File: rtl/medidor_carga_bateria.sv
//------------------------------------------------------------------------------
// Module  : medidor_carga_bateria
// Brief   : Dual-battery charge gauge with prescaled levels and source FSM.
//           Optional MEDIDOR_RETORNO_B1_EN: return to B1 once it is full.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module medidor_carga_bateria #(
  parameter int unsigned PULSOS_POR_NIVEL = 16,
  parameter logic [3:0]  CARGA_INICIAL    = 4'd15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  medidor_carga_bateria_if.slave        bat_io
);

  localparam int unsigned    SW      = $clog2(PULSOS_POR_NIVEL);
  localparam logic [SW-1:0]  SUB_MAX = SW'(PULSOS_POR_NIVEL - 1);

  typedef enum logic [1:0] {
    SIN_ENERGIA = 2'b00,
    USA_B1      = 2'b01,
    USA_B2      = 2'b10
  } estado_t;

  estado_t       estado_q;
  logic [3:0]    nivel1_q, nivel1_d, nivel2_q, nivel2_d;
  logic [SW-1:0] sub1_q, sub1_d, sub2_q, sub2_d;
  logic          actualizado_q, perdido_q;

  logic          w_vacia1, w_vacia2;
  logic          w_con_b1, w_con_b2, w_perdido;

  // Saturating +1/-1 on the {nivel,sub} pair; simultaneous add and remove cancel.
  function automatic logic [SW+3:0] f_paso(input logic [3:0] n, input logic [SW-1:0] s,
                                           input logic mas, input logic menos);
    logic [3:0]    n_r;
    logic [SW-1:0] s_r;
    n_r = n;
    s_r = s;
    if (mas && !menos) begin
      if (!(n == 4'd15 && s == SUB_MAX)) begin
        if (s == SUB_MAX) begin
          s_r = '0;
          n_r = n + 4'd1;
        end else begin
          s_r = s + SW'(1);
        end
      end
    end else if (menos && !mas) begin
      if (!(n == 4'd0 && s == '0)) begin
        if (s == '0) begin
          s_r = SUB_MAX;
          n_r = n - 4'd1;
        end else begin
          s_r = s - SW'(1);
        end
      end
    end
    return {n_r, s_r};
  endfunction

  assign w_vacia1  = (nivel1_q == 4'd0) && (sub1_q == '0);
  assign w_vacia2  = (nivel2_q == 4'd0) && (sub2_q == '0);
  assign w_con_b1  = bat_io.consumo && (estado_q == USA_B1);
  assign w_con_b2  = bat_io.consumo && (estado_q == USA_B2);
  assign w_perdido = bat_io.consumo && ((estado_q == SIN_ENERGIA) ||
                                        (estado_q == USA_B1 && w_vacia1) ||
                                        (estado_q == USA_B2 && w_vacia2));

`ifdef MEDIDOR_RETORNO_B1_EN
  logic w_llena1;
  assign w_llena1 = (nivel1_q == 4'd15) && (sub1_q == SUB_MAX);
`endif

  always_comb begin
    {nivel1_d, sub1_d} = f_paso(nivel1_q, sub1_q, bat_io.recarga1, w_con_b1);
    {nivel2_d, sub2_d} = f_paso(nivel2_q, sub2_q, bat_io.recarga2, w_con_b2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nivel1_q      <= CARGA_INICIAL;
      nivel2_q      <= CARGA_INICIAL;
      sub1_q        <= '0;
      sub2_q        <= '0;
      actualizado_q <= 1'b0;
      perdido_q     <= 1'b0;
    end else begin
      nivel1_q      <= nivel1_d;
      nivel2_q      <= nivel2_d;
      sub1_q        <= sub1_d;
      sub2_q        <= sub2_d;
      actualizado_q <= (nivel1_d != nivel1_q) || (nivel2_d != nivel2_q);
      perdido_q     <= w_perdido;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= USA_B1;
    end else begin
      case (estado_q)
        USA_B1: begin
          if (w_vacia1) estado_q <= w_vacia2 ? SIN_ENERGIA : USA_B2;
        end
        USA_B2: begin
          if (w_vacia2) begin
            estado_q <= w_vacia1 ? SIN_ENERGIA : USA_B1;
          end
`ifdef MEDIDOR_RETORNO_B1_EN
          else if (w_llena1) begin
            estado_q <= USA_B1;
          end
`endif
        end
        SIN_ENERGIA: begin
          // Prefer the fuller battery; ties go to B1.
          if (!w_vacia1 || !w_vacia2)
            estado_q <= ({nivel1_q, sub1_q} >= {nivel2_q, sub2_q}) ? USA_B1 : USA_B2;
        end
        default: estado_q <= USA_B1;
      endcase
    end
  end

  assign bat_io.carga_bateria1  = nivel1_q;
  assign bat_io.carga_bateria2  = nivel2_q;
  assign bat_io.fuente_activa   = estado_q;
  assign bat_io.actualizado     = actualizado_q;
  assign bat_io.consumo_perdido = perdido_q;

endmodule

`default_nettype wire

// File: tb/tb_medidor_carga_bateria.sv
//------------------------------------------------------------------------------
// Module  : tb_medidor_carga_bateria
// Brief   : Self-checking bench for medidor_carga_bateria (vectors, corner
//           sequences, randomized run against a charge-unit reference model).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_medidor_carga_bateria;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn_a, rn_b, rn_c;
  medidor_carga_bateria_if ifa ();
  medidor_carga_bateria_if ifb ();
  medidor_carga_bateria_if ifc ();

  medidor_carga_bateria #(.PULSOS_POR_NIVEL(4), .CARGA_INICIAL(4'd15)) dut_a (
    .clk(clk), .rst_n(rn_a), .bat_io(ifa));
  medidor_carga_bateria #(.PULSOS_POR_NIVEL(4), .CARGA_INICIAL(4'd1)) dut_b (
    .clk(clk), .rst_n(rn_b), .bat_io(ifb));
  medidor_carga_bateria #(.PULSOS_POR_NIVEL(5), .CARGA_INICIAL(4'd7)) dut_c (
    .clk(clk), .rst_n(rn_c), .bat_io(ifc));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: each battery is a plain count of charge units.
  int mu[3][2];
  int msrc[3];
  bit mupd[3];
  bit mperd[3];

  function automatic int mp(input int d);
    return (d == 2) ? 5 : 4;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_step(input int d, input int c, input bit rn, input bit con,
                            input bit r1, input bit r2);
    int p, full, o1, o2, a1, a2;
    p    = mp(d);
    full = 16 * p - 1;
    if (!rn) begin
      mu[d][0] = c * p; mu[d][1] = c * p;
      msrc[d] = 1; mupd[d] = 1'b0; mperd[d] = 1'b0;
      return;
    end
    o1 = mu[d][0];
    o2 = mu[d][1];
    a1 = (con && msrc[d] == 1) ? 1 : 0;
    a2 = (con && msrc[d] == 2) ? 1 : 0;
    mperd[d] = con && (msrc[d] == 0 || (msrc[d] == 1 && o1 == 0) || (msrc[d] == 2 && o2 == 0));
    mu[d][0] = clampi(o1 + int'(r1) - a1, full);
    mu[d][1] = clampi(o2 + int'(r2) - a2, full);
    mupd[d]  = (o1 / p != mu[d][0] / p) || (o2 / p != mu[d][1] / p);
    if (msrc[d] == 1) begin
      if (o1 == 0) msrc[d] = (o2 != 0) ? 2 : 0;
    end else if (msrc[d] == 2) begin
      if (o2 == 0) msrc[d] = (o1 != 0) ? 1 : 0;
`ifdef MEDIDOR_RETORNO_B1_EN
      else if (o1 == full) msrc[d] = 1;
`endif
    end else begin
      if (o1 != 0 || o2 != 0) msrc[d] = (o1 >= o2) ? 1 : 2;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 15, rn_a, ifa.consumo, ifa.recarga1, ifa.recarga2);
    model_step(1, 1,  rn_b, ifb.consumo, ifb.recarga1, ifb.recarga2);
    model_step(2, 7,  rn_c, ifc.consumo, ifc.recarga1, ifc.recarga2);
  end

  function automatic logic [11:0] mexp(input int d);
    return {4'(mu[d][0] / mp(d)), 4'(mu[d][1] / mp(d)), 2'(msrc[d]), mupd[d], mperd[d]};
  endfunction

  function automatic logic [11:0] obs(input int d);
    case (d)
      0:       return {ifa.carga_bateria1, ifa.carga_bateria2, ifa.fuente_activa,
                       ifa.actualizado, ifa.consumo_perdido};
      1:       return {ifb.carga_bateria1, ifb.carga_bateria2, ifb.fuente_activa,
                       ifb.actualizado, ifb.consumo_perdido};
      default: return {ifc.carga_bateria1, ifc.carga_bateria2, ifc.fuente_activa,
                       ifc.actualizado, ifc.consumo_perdido};
    endcase
  endfunction

  task automatic drv(input int d, input bit r, input bit c, input bit a, input bit b);
    case (d)
      0:       begin rn_a = r; ifa.consumo = c; ifa.recarga1 = a; ifa.recarga2 = b; end
      1:       begin rn_b = r; ifb.consumo = c; ifb.recarga1 = a; ifb.recarga2 = b; end
      default: begin rn_c = r; ifc.consumo = c; ifc.recarga1 = a; ifc.recarga2 = b; end
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rn, con, r1, r2;
    logic [3:0] l1, l2;
    logic [1:0] src;
    bit upd, perd;
  } vec_t;

  function automatic vec_t mkv(input bit rn, input bit con, input bit r1, input bit r2,
                               input int l1, input int l2, input int src,
                               input bit upd, input bit perd);
    vec_t v;
    v.rn = rn; v.con = con; v.r1 = r1; v.r2 = r2;
    v.l1 = 4'(l1); v.l2 = 4'(l2); v.src = 2'(src); v.upd = upd; v.perd = perd;
    return v;
  endfunction

  vec_t tab[22];

  initial begin
    // Vectors for dut_a (P=4, initial level 15); B1 starts at 60 units.
    tab[0] = mkv(0, 0, 0, 0, 15, 15, 1, 0, 0);
    tab[1] = mkv(1, 1, 0, 0, 14, 15, 1, 1, 0);
    for (int i = 2; i <= 4; i++) tab[i] = mkv(1, 1, 0, 0, 14, 15, 1, 0, 0);
    tab[5] = mkv(1, 1, 1, 0, 14, 15, 1, 0, 0);
    for (int i = 6; i <= 8; i++) tab[i] = mkv(1, 0, 1, 0, 14, 15, 1, 0, 0);
    tab[9] = mkv(1, 0, 1, 0, 15, 15, 1, 1, 0);
    for (int i = 10; i <= 14; i++) tab[i] = mkv(1, 0, 1, 0, 15, 15, 1, 0, 0);
    for (int i = 15; i <= 17; i++) tab[i] = mkv(1, 1, 0, 0, 15, 15, 1, 0, 0);
    tab[18] = mkv(1, 1, 0, 0, 14, 15, 1, 1, 0);
    tab[19] = mkv(0, 1, 0, 0, 15, 15, 1, 0, 0);
    tab[20] = mkv(1, 1, 0, 0, 14, 15, 1, 1, 0);
    tab[21] = mkv(1, 0, 0, 1, 14, 15, 1, 0, 0);

    for (int d = 0; d < 3; d++) drv(d, 0, 0, 0, 0);
    tick;

    for (int i = 0; i < 22; i++) begin
      drv(0, tab[i].rn, tab[i].con, tab[i].r1, tab[i].r2);
      tick;
      chk($sformatf("vec%0d", i), 32'(obs(0)),
          32'({tab[i].l1, tab[i].l2, tab[i].src, tab[i].upd, tab[i].perd}));
    end
    drv(0, 1, 0, 0, 0);

    // dut_b (P=4, initial level 1): depletion, switchover, no-energy, recovery.
    drv(1, 0, 0, 0, 0); tick;
    chk("b_reset", 32'(obs(1)), 32'({4'd1, 4'd1, 2'b01, 1'b0, 1'b0}));
    drv(1, 1, 1, 0, 0); tick;
    chk("b_con1_l1", 32'(ifb.carga_bateria1), 32'd0);
    chk("b_con1_upd", 32'(ifb.actualizado), 32'd1);
    repeat (3) tick;
    chk("b_dep_src_hold", 32'(ifb.fuente_activa), 32'b01);
    tick;
    chk("b_dep_perd", 32'(ifb.consumo_perdido), 32'd1);
    chk("b_switch_src", 32'(ifb.fuente_activa), 32'b10);
    chk("b_switch_l2", 32'(ifb.carga_bateria2), 32'd1);
    drv(1, 1, 0, 0, 0); tick;
    chk("b_perd_clear", 32'(ifb.consumo_perdido), 32'd0);
    drv(1, 1, 1, 0, 0); tick;
    chk("b2_con1", 32'({ifb.carga_bateria2, ifb.actualizado}), 32'({4'd0, 1'b1}));
    repeat (3) tick;
    chk("b2_last_unit", 32'({ifb.fuente_activa, ifb.consumo_perdido}), 32'({2'b10, 1'b0}));
    drv(1, 1, 0, 0, 0); tick;
    chk("b_sin_energia", 32'(ifb.fuente_activa), 32'b00);
    drv(1, 1, 1, 0, 0); tick;
    chk("b_sin_perd", 32'({ifb.consumo_perdido, ifb.carga_bateria2}), 32'({1'b1, 4'd0}));
    drv(1, 1, 0, 0, 1); tick;
    chk("b_rec_src_hold", 32'(ifb.fuente_activa), 32'b00);
    drv(1, 1, 0, 0, 0); tick;
    chk("b_rec_src", 32'(ifb.fuente_activa), 32'b10);
    drv(1, 1, 0, 0, 1); repeat (3) tick;
    chk("b_rec_l2", 32'(ifb.carga_bateria2), 32'd1);
    drv(1, 1, 0, 1, 0); repeat (63) tick;
    chk("b_full_l1", 32'({ifb.carga_bateria1, ifb.fuente_activa}), 32'({4'd15, 2'b10}));
    drv(1, 1, 0, 0, 0); tick;
`ifdef MEDIDOR_RETORNO_B1_EN
    chk("b_retorno", 32'(ifb.fuente_activa), 32'b01);
`else
    chk("b_no_retorno", 32'(ifb.fuente_activa), 32'b10);
`endif

    // Randomized run, alternating drain and charge phases.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        if (((cyc / 150) % 2) == 0)
          drv(d, ($urandom_range(0, 399) != 0), ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        else
          drv(d, ($urandom_range(0, 399) != 0), ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
      end
      tick;
      for (int d = 0; d < 3; d++)
        chk($sformatf("rand_dut%0d_cyc%0d", d, cyc), 32'(obs(d)), 32'(mexp(d)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
